// File: rtl/csa_adder_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// csa_adder_rr_scheduler_if
//
// Purpose:
//   Bundles the two requester handshakes and the two result return channels
//   of the shared carry-select adder scheduler.
//
// Parameters:
//   WIDTH  operand width; result sums are WIDTH+1 bits
//
// Signals:
//   req0_valid / req1_valid   requester offers an operand pair
//   req0_ready / req1_ready   pair accepted this cycle (combinational grant)
//   req0_a/_b, req1_a/_b      operand pairs, WIDTH bits each
//   res0_valid / res1_valid   one-cycle result pulse for the owning requester
//   res0_sum / res1_sum       result, WIDTH+1 bits, 0 when not valid
//
// Modports:
//   master  client side (drives requests, receives ready and results)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface csa_adder_rr_scheduler_if #(
  parameter int WIDTH = 28
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res0_valid;
  logic [WIDTH:0]   res0_sum;
  logic             res1_valid;
  logic [WIDTH:0]   res1_sum;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_sum,
    input  res1_valid, res1_sum
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output res0_valid, res0_sum,
    output res1_valid, res1_sum
  );

endinterface

// File: rtl/csa_adder_rr_scheduler.sv
// -----------------------------------------------------------------------------
// csa_adder_rr_scheduler
//
// Purpose:
//   Shares one pipelined WIDTH-bit carry-select adder (external instance,
//   LAT cycles from operand sample to valid sum) between two requesters.
//   A round-robin arbiter admits at most one operand pair per clock; a
//   LAT-deep tag pipe follows every accepted pair through the adder and
//   steers the returning sum to the requester that owns it.
//
// Parameters:
//   WIDTH  operand width (sums are WIDTH+1 bits)
//   LAT    adder latency in clock cycles
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   bus        csa_adder_rr_scheduler_if.slave: both request handshakes and
//              both result channels
//   add_a      to adder operand a (granted pair, 0 when idle)
//   add_b      to adder operand b (granted pair, 0 when idle)
//   add_cin    to adder carry in, always 0
//   add_sum    from adder sum, WIDTH+1 bits
//   stat0_cnt  (ARB_STATS_EN only) saturating transfer count, requester 0
//   stat1_cnt  (ARB_STATS_EN only) saturating transfer count, requester 1
//
// Configuration:
//   ARB_STATS_EN  when defined, adds the two 16-bit saturating transfer
//                 counters and their output ports. Otherwise they are absent
//                 and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module csa_adder_rr_scheduler #(
  parameter int WIDTH = 28,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  csa_adder_rr_scheduler_if.slave  bus,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH:0]           add_sum
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]              stat0_cnt,
  output logic [15:0]              stat1_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    // Counter sticks at all-ones instead of wrapping back to zero.
    if (cnt == 16'hFFFF) begin
      return cnt;
    end
    return cnt + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  // Priority pointer: 0 favours requester 0 on contention, 1 favours requester 1.
  logic           ptr_q;
  logic           ptr_d;

  logic           grant0;
  logic           grant1;
  logic           xfer;
  logic           gnt_id;

  // Tag pipe: one {vld, id} entry per adder stage. Index LAT-1 lines up with
  // the sum currently presented on add_sum.
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;
  logic [LAT-1:0] id_q;
  logic [LAT-1:0] id_d;

  logic           out_vld;
  logic           out_id;

  // ---------------------------------------------------------------------------
  // Stage p0: arbitration and operand steering (combinational)
  // ---------------------------------------------------------------------------
  // Grants are gated by rstn so that nothing is accepted while reset is held,
  // even though the reset itself is asynchronous to the clock.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rstn) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // ready is the grant itself, so a grant always means a transfer.
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign xfer           = grant0 | grant1;
  assign gnt_id         = grant1;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (grant0) begin
      add_a = bus.req0_a;
      add_b = bus.req0_b;
    end else if (grant1) begin
      add_a = bus.req1_a;
      add_b = bus.req1_b;
    end
  end

  assign add_cin = 1'b0;

  // After every transfer the winner yields priority to the other side; with
  // no transfer the pointer holds.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = ~gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stages p1..pLAT: tag pipe shadowing the adder pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = xfer;
    id_d[0]  = gnt_id;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // Only the valid bits are control; clearing them is enough to discard
  // everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Owner ids are qualified by vld_q and need no reset.
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

  // ---------------------------------------------------------------------------
  // Result return: route the adder output to its owner
  // ---------------------------------------------------------------------------
  assign out_vld = vld_q[LAT-1];
  assign out_id  = id_q[LAT-1];

  always_comb begin
    bus.res0_valid = 1'b0;
    bus.res1_valid = 1'b0;
    bus.res0_sum   = '0;
    bus.res1_sum   = '0;
    if (out_vld) begin
      if (out_id) begin
        bus.res1_valid = 1'b1;
        bus.res1_sum   = add_sum;
      end else begin
        bus.res0_valid = 1'b1;
        bus.res0_sum   = add_sum;
      end
    end
  end

`ifdef ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Transfer statistics
  // ---------------------------------------------------------------------------
  logic [15:0] stat0_cnt_q;
  logic [15:0] stat0_cnt_d;
  logic [15:0] stat1_cnt_q;
  logic [15:0] stat1_cnt_d;

  always_comb begin
    stat0_cnt_d = stat0_cnt_q;
    stat1_cnt_d = stat1_cnt_q;
    if (grant0) begin
      stat0_cnt_d = sat_inc16(stat0_cnt_q);
    end
    if (grant1) begin
      stat1_cnt_d = sat_inc16(stat1_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat0_cnt_q <= '0;
      stat1_cnt_q <= '0;
    end else begin
      stat0_cnt_q <= stat0_cnt_d;
      stat1_cnt_q <= stat1_cnt_d;
    end
  end

  assign stat0_cnt = stat0_cnt_q;
  assign stat1_cnt = stat1_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (!rstn)
    !(grant0 && grant1));

  a_one_result : assert property (@(posedge clk) disable iff (!rstn)
    !(bus.res0_valid && bus.res1_valid));

endmodule

// File: tb/tb_csa_adder_rr_scheduler.sv
module tb_csa_adder_rr_scheduler;

  localparam int WIDTH = 28;
  localparam int LAT   = 2;

  logic             clk;
  logic             rstn;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   adder_p0;
  logic [WIDTH:0]   adder_p1;
`ifdef ARB_STATS_EN
  logic [15:0]      stat0_cnt;
  logic [15:0]      stat1_cnt;
`endif

  int n_checks;
  int n_errors;

  csa_adder_rr_scheduler_if #(.WIDTH(WIDTH)) bus ();

  csa_adder_rr_scheduler #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum)
`ifdef ARB_STATS_EN
    ,
    .stat0_cnt (stat0_cnt),
    .stat1_cnt (stat1_cnt)
`endif
  );

  // Two-stage pipelined adder stand-in: operands sampled at an edge, sum
  // visible LAT edges later.
  always_ff @(posedge clk) begin
    adder_p0 <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    adder_p1 <= adder_p0;
  end
  assign add_sum = adder_p1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Contention vectors: transfer t is owned by requester own_t[t].
  logic [WIDTH-1:0] ta [4] = '{28'h0000100, 28'h1000000, 28'h0000200, 28'h0ABCDEF};
  logic [WIDTH-1:0] tb [4] = '{28'h0000011, 28'h0000333, 28'h0000022, 28'h0111111};
  logic [WIDTH:0]   ts [4] = '{29'h0000111, 29'h1000333, 29'h0000222, 29'h0BCDF00};
  int               own_t [4] = '{0, 1, 0, 1};

  initial begin
    int idx0;
    int idx1;
    int t;
    n_checks = 0;
    n_errors = 0;

    // ---------------- Reset with both requesters active ----------------
    rstn           = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_a     = 28'h1234567;
    bus.req0_b     = 28'h0000001;
    bus.req1_a     = 28'h7654321;
    bus.req1_b     = 28'h0000002;
    repeat (2) tick();
    #1;
    check_eq("rst_ready0",  bus.req0_ready, 0);
    check_eq("rst_ready1",  bus.req1_ready, 0);
    check_eq("rst_res0_v",  bus.res0_valid, 0);
    check_eq("rst_res1_v",  bus.res1_valid, 0);
    check_eq("rst_add_a",   add_a, 0);
    check_eq("rst_add_b",   add_b, 0);
    check_eq("rst_res0_s",  bus.res0_sum, 0);
`ifdef ARB_STATS_EN
    check_eq("rst_stat0",   stat0_cnt, 0);
    check_eq("rst_stat1",   stat1_cnt, 0);
`endif

    // ---------------- Single requester 1 + 2 ----------------
    idle_inputs();
    rstn = 1'b1;
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_a     = 28'h0000001;
    bus.req0_b     = 28'h0000002;
    #1;
    check_eq("t2_ready0",  bus.req0_ready, 1);
    check_eq("t2_ready1",  bus.req1_ready, 0);
    check_eq("t2_add_a",   add_a, 28'h0000001);
    check_eq("t2_add_b",   add_b, 28'h0000002);
    check_eq("t2_cin",     add_cin, 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check_eq("t2_early",   bus.res0_valid, 0);
    tick();
    check_eq("t2_res0_v",  bus.res0_valid, 1);
    check_eq("t2_res0_s",  bus.res0_sum, 29'h0000003);
    check_eq("t2_res1_v",  bus.res1_valid, 0);
    tick();
    check_eq("t2_pulse",   bus.res0_valid, 0);
    check_eq("t2_sum0",    bus.res0_sum, 0);

    // ---------------- Contention: grants 0,1,0,1 ----------------
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_a     = ta[0];
    bus.req0_b     = tb[0];
    bus.req1_valid = 1'b1;
    bus.req1_a     = ta[1];
    bus.req1_b     = tb[1];
    idx0 = 0;
    idx1 = 1;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (j < 4) begin
        check_eq($sformatf("t3_ready0_%0d", j), bus.req0_ready, (own_t[j] == 0));
        check_eq($sformatf("t3_ready1_%0d", j), bus.req1_ready, (own_t[j] == 1));
        check_eq($sformatf("t3_add_a_%0d", j),  add_a, ta[j]);
      end else begin
        check_eq($sformatf("t3_idle_%0d", j),   bus.req0_ready | bus.req1_ready, 0);
      end
      if (j >= 2) begin
        t = j - 2;
        check_eq($sformatf("t3_res0_v_%0d", t), bus.res0_valid, (own_t[t] == 0));
        check_eq($sformatf("t3_res1_v_%0d", t), bus.res1_valid, (own_t[t] == 1));
        check_eq($sformatf("t3_sum_%0d", t),
                 (own_t[t] == 0) ? bus.res0_sum : bus.res1_sum, ts[t]);
      end
      tick();
      if (j < 4) begin
        if (own_t[j] == 0) begin
          idx0 = j + 2;
          if (idx0 < 4) begin
            bus.req0_a = ta[idx0];
            bus.req0_b = tb[idx0];
          end else begin
            bus.req0_valid = 1'b0;
          end
        end else begin
          idx1 = j + 2;
          if (idx1 < 4) begin
            bus.req1_a = ta[idx1];
            bus.req1_b = tb[idx1];
          end else begin
            bus.req1_valid = 1'b0;
          end
        end
      end
    end

    // ---------------- Overflow through requester 1 ----------------
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_a     = 28'hFFFFFFF;
    bus.req1_b     = 28'hFFFFFFF;
    #1;
    check_eq("t4_ready1",  bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check_eq("t4_res1_v",  bus.res1_valid, 1);
    check_eq("t4_res1_s",  bus.res1_sum, 29'h1FFFFFFE);
    check_eq("t4_res0_v",  bus.res0_valid, 0);

    // ---------------- Reset while a result is in flight ----------------
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_a     = 28'h0000005;
    bus.req0_b     = 28'h0000006;
    #1;
    check_eq("t5_ready0",  bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    rstn           = 1'b0;
    #1;
    check_eq("t5_in_rst",  bus.res0_valid, 0);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("t5_res0_v_%0d", k), bus.res0_valid, 0);
      check_eq($sformatf("t5_res1_v_%0d", k), bus.res1_valid, 0);
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check_eq("t5_ptr_r0",  bus.req0_ready, 1);
    check_eq("t5_ptr_r1",  bus.req1_ready, 0);
    tick();
    idle_inputs();

`ifdef ARB_STATS_EN
    // ---------------- Transfer statistics ----------------
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_a     = 28'h0000001;
    bus.req1_b     = 28'h0000001;
    repeat (100) tick();
    bus.req1_valid = 1'b0;
    #1;
    check_eq("t6_stat1",   stat1_cnt, 16'd100);
    check_eq("t6_stat0",   stat0_cnt, 16'd0);
    bus.req1_valid = 1'b1;
    force dut.stat1_cnt_q = 16'hFFFF;
    tick();
    release dut.stat1_cnt_q;
    repeat (2) tick();
    bus.req1_valid = 1'b0;
    #1;
    check_eq("t6_sat",     stat1_cnt, 16'hFFFF);
    check_eq("t6_stat0b",  stat0_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
